// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester and CDB signals of cdb_arbiter; slave = arbiter side, master = requesters/ROB side
interface cdb_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int XLEN = 64,
  parameter int ROB_IDX_LEN = 6,
  parameter int ROB_EXCEPT_LEN = 5
);
  logic [N_REQ-1:0] rs_valid_i;
  logic [N_REQ-1:0] rs_ready_o;
  logic [N_REQ-1:0][ROB_IDX_LEN-1:0] rs_idx_i;
  logic [N_REQ-1:0][XLEN-1:0] rs_data_i;
  logic [N_REQ-1:0] rs_except_raised_i;
  logic [N_REQ-1:0][ROB_EXCEPT_LEN-1:0] rs_except_code_i;
  logic rob_ready_i;
  logic cdb_valid_o;
  logic [ROB_IDX_LEN-1:0] cdb_idx_o;
  logic [XLEN-1:0] cdb_data_o;
  logic cdb_except_raised_o;
  logic [ROB_EXCEPT_LEN-1:0] cdb_except_o;
  modport slave (
    input rs_valid_i, rs_idx_i, rs_data_i, rs_except_raised_i, rs_except_code_i, rob_ready_i,
    output rs_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o
  );
  modport master (
    output rs_valid_i, rs_idx_i, rs_data_i, rs_except_raised_i, rs_except_code_i, rob_ready_i,
    input rs_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with one-entry output stage; ports clk_i, rst_n_i (sync active-low), flush_i, bus (requesters in, one-hot rs_ready_o, cdb_* broadcast held until rob_ready_i)
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int XLEN = 64,
  parameter int ROB_IDX_LEN = 6,
  parameter int ROB_EXCEPT_LEN = 5
) (
  input logic clk_i,
  input logic rst_n_i,
  input logic flush_i,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] prio;
  logic [PW-1:0] g;
  logic [PW:0] j;
  logic hit;
  logic free;
  logic en;
  assign free = !bus.cdb_valid_o || bus.rob_ready_i;
  assign en = free && rst_n_i && !flush_i;
  always_comb begin
    hit = 1'b0;
    g = '0;
    j = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = {1'b0, prio} + (PW+1)'(k);
      j = j >= (PW+1)'(N_REQ) ? j - (PW+1)'(N_REQ) : j;
      if (!hit && bus.rs_valid_i[j[PW-1:0]]) begin
        hit = 1'b1;
        g = j[PW-1:0];
      end
    end
  end
  assign bus.rs_ready_o = en && hit ? {{(N_REQ-1){1'b0}}, 1'b1} << g : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bus.cdb_valid_o <= 1'b0;
      bus.cdb_idx_o <= '0;
      bus.cdb_data_o <= '0;
      bus.cdb_except_raised_o <= 1'b0;
      bus.cdb_except_o <= '0;
      prio <= '0;
    end else if (flush_i) begin
      bus.cdb_valid_o <= 1'b0;
      prio <= '0;
    end else if (free) begin
      bus.cdb_valid_o <= hit;
      if (hit) begin
        bus.cdb_idx_o <= bus.rs_idx_i[g];
        bus.cdb_data_o <= bus.rs_data_i[g];
        bus.cdb_except_raised_o <= bus.rs_except_raised_i[g];
        bus.cdb_except_o <= bus.rs_except_code_i[g];
        prio <= g == PW'(N_REQ-1) ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized check of cdb_arbiter against a queue-free behavioural model
module tb_cdb_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  cdb_arbiter_if #(.N_REQ(N), .XLEN(64), .ROB_IDX_LEN(6), .ROB_EXCEPT_LEN(5)) bus();
  cdb_arbiter #(.N_REQ(N), .XLEN(64), .ROB_IDX_LEN(6), .ROB_EXCEPT_LEN(5)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic pv [N];
  logic [5:0] pidx [N];
  logic [63:0] pdata [N];
  logic pexr [N];
  logic [4:0] pexc [N];
  int mprio = 0;
  logic mv = 1'b0;
  logic [5:0] midx = '0;
  logic [63:0] mdata = '0;
  logic mexr = 1'b0;
  logic [4:0] mexc = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic rr, input int pnew);
    int eg;
    logic [N-1:0] er;
    chk("cdb_valid", bus.cdb_valid_o, mv);
    chk("cdb_idx", bus.cdb_idx_o, midx);
    chk("cdb_data", bus.cdb_data_o, mdata);
    chk("cdb_exr", bus.cdb_except_raised_o, mexr);
    chk("cdb_exc", bus.cdb_except_o, mexc);
    rst_n = r;
    flush = f;
    bus.rob_ready_i = rr;
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && int'($urandom_range(99)) < pnew) begin
        pv[i] = 1'b1;
        pidx[i] = 6'($urandom);
        pdata[i] = {$urandom, $urandom};
        pexr[i] = 1'($urandom);
        pexc[i] = 5'($urandom);
      end
      bus.rs_valid_i[i] = pv[i];
      bus.rs_idx_i[i] = pidx[i];
      bus.rs_data_i[i] = pdata[i];
      bus.rs_except_raised_i[i] = pexr[i];
      bus.rs_except_code_i[i] = pexc[i];
    end
    #1;
    eg = -1;
    if (r && !f && (!mv || rr))
      for (int k = 0; k < N; k++)
        if (eg < 0 && pv[(mprio + k) % N]) eg = (mprio + k) % N;
    er = eg >= 0 ? N'(1) << eg : '0;
    chk("rs_ready", bus.rs_ready_o, er);
    @(posedge clk);
    if (!r) begin
      mv = 1'b0; midx = '0; mdata = '0; mexr = 1'b0; mexc = '0; mprio = 0;
    end else if (f) begin
      mv = 1'b0; mprio = 0;
    end else if (!mv || rr) begin
      mv = eg >= 0;
      if (eg >= 0) begin
        midx = pidx[eg]; mdata = pdata[eg]; mexr = pexr[eg]; mexc = pexc[eg];
        mprio = (eg + 1) % N;
        pv[eg] = 1'b0;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pidx[i] = '0; pdata[i] = '0; pexr[i] = 1'b0; pexc[i] = '0;
    end
    bus.rs_valid_i = '0;
    bus.rs_idx_i = '0;
    bus.rs_data_i = '0;
    bus.rs_except_raised_i = '0;
    bus.rs_except_code_i = '0;
    bus.rob_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 1'b1, 100);
    for (int c = 0; c < 16; c++) step(1'b1, 1'b0, 1'b1, 100);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0, 100);
    step(1'b1, 1'b1, 1'b0, 100);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b1, 100);
    for (int c = 0; c < 3000; c++)
      step($urandom_range(99) > 1, $urandom_range(99) < 4, $urandom_range(99) < 65, int'($urandom_range(60)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
